// File: rtl/refill_arbiter_if.sv
// Cache-refill port bundle between the two L1 miss handlers, the refill
// arbiter and the backing-memory read port.
interface refill_arbiter_if #(
    parameter int BLOCK_WORDS = 16,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);

    // icache miss handler
    logic              ic_req_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic              ic_cancel_i;
    logic              ic_rvalid_o;
    logic              ic_done_o;

    // dcache miss handler
    logic              dc_req_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic              dc_rvalid_o;
    logic              dc_done_o;

    // beat steering shared by both caches
    logic [DATA_W-1:0] rdata_o;
    logic [IDX_W-1:0]  word_idx_o;

    // backing-memory read port
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    // Handshake: a burst is handed over on the clock edge where mem_req_o and
    // mem_ack_i are both 1; until then mem_req_o/mem_addr_o stay stable. Cache
    // requests are level requests held until the matching done pulse.
    modport slave (
        input  ic_req_i, ic_addr_i, ic_cancel_i,
        input  dc_req_i, dc_addr_i,
        input  mem_ack_i, mem_rvalid_i, mem_rdata_i,
        output ic_rvalid_o, ic_done_o, dc_rvalid_o, dc_done_o,
        output rdata_o, word_idx_o,
        output mem_req_o, mem_addr_o
    );

    modport master (
        output ic_req_i, ic_addr_i, ic_cancel_i,
        output dc_req_i, dc_addr_i,
        output mem_ack_i, mem_rvalid_i, mem_rdata_i,
        input  ic_rvalid_o, ic_done_o, dc_rvalid_o, dc_done_o,
        input  rdata_o, word_idx_o,
        input  mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/refill_arbiter.sv
// Round-robin arbiter sharing one memory read port between icache and dcache
// line refills: issues a line-aligned burst and steers counted beats back.
module refill_arbiter #(
    parameter int BLOCK_WORDS = 16,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    refill_arbiter_if.slave   bus,
    output logic [1:0]        dbg_state_o
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = $clog2(BLOCK_WORDS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q,  last_d;
    logic [IDX_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    logic ic_valid;
    logic grant_ic;
    logic beat_v;
    logic last_beat;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            owner_q <= OWN_DC;
            last_q  <= OWN_DC;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    assign beat_v    = (state_q == S_XFER) && bus.mem_rvalid_i;
    assign last_beat = beat_v && (cnt_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ic_valid = bus.ic_req_i && !bus.ic_cancel_i;
        grant_ic = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ic_valid || bus.dc_req_i) begin
                    // On a tie the requester not served last wins.
                    grant_ic = ic_valid && (!bus.dc_req_i || (last_q == OWN_DC));
                    owner_d  = grant_ic ? OWN_IC : OWN_DC;
                    last_d   = grant_ic ? OWN_IC : OWN_DC;
                    addr_d   = (grant_ic ? bus.ic_addr_i : bus.dc_addr_i) & LINE_MASK;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                // An accepted burst must be drained, so ack outranks cancel.
                if (bus.mem_ack_i) begin
                    state_d = S_XFER;
                    cnt_d   = '0;
                end else if ((owner_q == OWN_IC) && bus.ic_cancel_i) begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (beat_v) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_req_o   = (state_q == S_REQ);
        bus.mem_addr_o  = (state_q == S_REQ) ? addr_q : '0;
        bus.ic_rvalid_o = beat_v && (owner_q == OWN_IC);
        bus.dc_rvalid_o = beat_v && (owner_q == OWN_DC);
        bus.ic_done_o   = last_beat && (owner_q == OWN_IC);
        bus.dc_done_o   = last_beat && (owner_q == OWN_DC);
        bus.rdata_o     = beat_v ? bus.mem_rdata_i : '0;
        bus.word_idx_o  = beat_v ? cnt_q : '0;
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed-plus-random bench for refill_arbiter with a line/round-robin model.
module tb_refill_arbiter;
    localparam int BW         = 16;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int IW         = $clog2(BW);
    localparam int LINE_BYTES = BW * DW / 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q[$];
    bit            model_last_ic = 1'b0;

    always #5 clk = ~clk;

    refill_arbiter_if #(.BLOCK_WORDS(BW), .ADDR_W(AW), .DATA_W(DW)) bus();

    refill_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic bit arb_ic(input bit ic, input bit dc);
        if (ic && dc) return !model_last_ic;
        return ic;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {bus.mem_req_o, bus.ic_rvalid_o, bus.dc_rvalid_o,
                            bus.ic_done_o, bus.dc_done_o}, 64'd0);
        chk({tag, "_idx"},   bus.word_idx_o, 64'd0);
        chk({tag, "_rdata"}, bus.rdata_o,    64'd0);
        chk({tag, "_addr"},  bus.mem_addr_o, 64'd0);
    endtask

    // Starts in the first REQ cycle; returns in the IDLE cycle after done.
    task automatic run_burst(input bit own_ic, input logic [AW-1:0] a, input int gap_mode,
                             input int ack_wait, input bit cancel_at_ack,
                             input bit cancel_in_xfer, input int abort_beat);
        logic [DW-1:0] d;
        int gaps;
        chk("mem_req_up", bus.mem_req_o, 64'd1);
        chk("mem_addr", bus.mem_addr_o, line_of(a));
        for (int w = 0; w < ack_wait; w++) begin
            step();
            chk("req_hold", bus.mem_req_o, 64'd1);
            chk("addr_hold", bus.mem_addr_o, line_of(a));
        end
        bus.mem_ack_i = 1'b1;
        if (cancel_at_ack) bus.ic_cancel_i = 1'b1;
        step();
        bus.mem_ack_i   = 1'b0;
        bus.ic_cancel_i = 1'b0;
        #1;
        chk("req_drop", bus.mem_req_o, 64'd0);
        for (int i = 0; i < BW; i++) begin
            gaps = (gap_mode == 1) ? int'($urandom_range(0, 2)) :
                   ((gap_mode == 2) && (i > 0)) ? 2 : 0;
            repeat (gaps) begin
                bus.mem_rvalid_i = 1'b0;
                bus.mem_rdata_i  = $urandom;
                bus.ic_cancel_i  = cancel_in_xfer ? 1'($urandom_range(0, 1)) : 1'b0;
                #1;
                chk("gap_rvalid", {bus.ic_rvalid_o, bus.dc_rvalid_o}, 64'd0);
                chk("gap_done", {bus.ic_done_o, bus.dc_done_o}, 64'd0);
                step();
            end
            d = $urandom;
            bus.mem_rdata_i  = d;
            bus.mem_rvalid_i = 1'b1;
            bus.ic_cancel_i  = cancel_in_xfer ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == abort_beat) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk_quiet("async_rst");
                bus.mem_rvalid_i = 1'b0;
                bus.ic_cancel_i  = 1'b0;
                return;
            end
            exp_q.push_back(d);
            #1;
            chk("own_rvalid",   own_ic ? bus.ic_rvalid_o : bus.dc_rvalid_o, 64'd1);
            chk("other_rvalid", own_ic ? bus.dc_rvalid_o : bus.ic_rvalid_o, 64'd0);
            chk("word_idx", bus.word_idx_o, 64'(i));
            chk("rdata", bus.rdata_o, exp_q.pop_front());
            chk("own_done",   own_ic ? bus.ic_done_o : bus.dc_done_o, 64'(i == BW - 1));
            chk("other_done", own_ic ? bus.dc_done_o : bus.ic_done_o, 64'd0);
            step();
        end
        bus.mem_rvalid_i = 1'b0;
        bus.ic_cancel_i  = 1'b0;
        if (own_ic) bus.ic_req_i = 1'b0;
        else        bus.dc_req_i = 1'b0;
        #1;
        chk("bubble_req", bus.mem_req_o, 64'd0);
        chk("bubble_done", {bus.ic_done_o, bus.dc_done_o}, 64'd0);
    endtask

    // Raises the given requests in IDLE and serves the winner then any loser.
    task automatic serve(input bit ic, input bit dc, input logic [AW-1:0] ia,
                         input logic [AW-1:0] da, input int gap_mode);
        bit win_ic;
        bus.ic_req_i  = ic;
        bus.ic_addr_i = ia;
        bus.dc_req_i  = dc;
        bus.dc_addr_i = da;
        #1;
        chk("idle_no_req", bus.mem_req_o, 64'd0);
        win_ic = arb_ic(ic, dc);
        model_last_ic = win_ic;
        step();
        run_burst(win_ic, win_ic ? ia : da, gap_mode, int'($urandom_range(0, 2)), 1'b0, 1'b0, -1);
        if (ic && dc) begin
            step();
            win_ic = arb_ic(!win_ic, win_ic);
            model_last_ic = win_ic;
            run_burst(win_ic, win_ic ? ia : da, gap_mode, int'($urandom_range(0, 2)), 1'b0, 1'b0, -1);
        end
    endtask

    initial begin
        bus.ic_req_i     = 1'b0;
        bus.ic_addr_i    = '0;
        bus.ic_cancel_i  = 1'b0;
        bus.dc_req_i     = 1'b0;
        bus.dc_addr_i    = '0;
        bus.mem_ack_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        rst_n = 1'b0;
        step();
        step();
        chk_quiet("reset");
        rst_n = 1'b1;
        step();

        // single icache refill at 0x1234 -> burst at 0x1200
        serve(1'b1, 1'b0, 32'h0000_1234, 32'h0, 0);

        // tie out of reset: IC first, DC after a one-cycle bubble, then IC again
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_last_ic = 1'b0;
        step();
        serve(1'b1, 1'b1, $urandom, $urandom, 0);
        serve(1'b1, 1'b1, $urandom, $urandom, 1);

        // gapped beats 1,0,0,1,...
        serve(1'b0, 1'b1, 32'h0, $urandom, 2);

        // cancel in REQ after three unacked cycles; pending dcache then served
        begin
            logic [AW-1:0] ia, da;
            ia = $urandom;
            da = $urandom;
            bus.ic_req_i  = 1'b1;
            bus.ic_addr_i = ia;
            model_last_ic = arb_ic(1'b1, 1'b0);
            step();
            bus.dc_req_i  = 1'b1;
            bus.dc_addr_i = da;
            #1;
            chk("cancel_req1", bus.mem_req_o, 64'd1);
            chk("cancel_addr", bus.mem_addr_o, line_of(ia));
            step();
            chk("cancel_req2", bus.mem_req_o, 64'd1);
            step();
            bus.ic_cancel_i = 1'b1;
            #1;
            chk("cancel_req3", bus.mem_req_o, 64'd1);
            step();
            bus.ic_cancel_i = 1'b0;
            bus.ic_req_i    = 1'b0;
            #1;
            chk("cancel_drop", bus.mem_req_o, 64'd0);
            chk("cancel_no_done", bus.ic_done_o, 64'd0);
            model_last_ic = arb_ic(1'b0, 1'b1);
            step();
            run_burst(model_last_ic, da, 1, 0, 1'b0, 1'b0, -1);
        end

        // cancel coincident with ack, then random cancels during the transfer
        begin
            logic [AW-1:0] ia;
            ia = $urandom;
            bus.ic_req_i  = 1'b1;
            bus.ic_addr_i = ia;
            model_last_ic = arb_ic(1'b1, 1'b0);
            step();
            run_burst(model_last_ic, ia, 1, 1, 1'b1, 1'b1, -1);
        end

        // async reset at beat 7, then a fresh refill restarts at word 0
        begin
            logic [AW-1:0] ia;
            ia = $urandom;
            bus.ic_req_i  = 1'b1;
            bus.ic_addr_i = ia;
            model_last_ic = arb_ic(1'b1, 1'b0);
            step();
            run_burst(model_last_ic, ia, 0, 0, 1'b0, 1'b0, 7);
            bus.ic_req_i = 1'b0;
            step();
            chk_quiet("held_rst");
            step();
            rst_n = 1'b1;
            model_last_ic = 1'b0;
            step();
            chk_quiet("post_rst");
            serve(1'b1, 1'b0, $urandom, 32'h0, 1);
        end

        // random mix of single and tied requests
        for (int n = 0; n < 6; n++) begin
            bit ic, dc;
            ic = 1'($urandom_range(0, 1));
            dc = 1'($urandom_range(0, 1));
            if (!ic && !dc) dc = 1'b1;
            serve(ic, dc, $urandom, $urandom, 1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/refill_arbiter.md
Name: refill_arbiter

Overview:
- Shares the single backing-memory read port between the L1 instruction cache and the L1 data cache miss handlers.
- Accepts one line-refill request at a time and arbitrates simultaneous requests round-robin.
- Issues a line-aligned burst address to memory, counts returned beats, and steers each data beat to the owning cache with a word index.
- Sits between the cache controllers and the memory interface.

Parameters:
BLOCK_WORDS, 16, words per cache line / beats per burst (power of 2, >=2)
ADDR_W, 32, byte address width
DATA_W, 32, beat width in bits

Ports:
clk_i  input  1  clock, rising edge
reset_n_i  input  1  asynchronous active-low reset
ic_req_i  input  1  icache refill request, held until ic_done_o
ic_addr_i  input  ADDR_W  icache miss byte address
ic_cancel_i  input  1  icache redirect (flush); abandons a not-yet-accepted icache request
dc_req_i  input  1  dcache refill request, held until dc_done_o
dc_addr_i  input  ADDR_W  dcache miss byte address
ic_rvalid_o  output  1  beat valid for icache
dc_rvalid_o  output  1  beat valid for dcache
rdata_o  output  DATA_W  beat data (shared by both caches)
word_idx_o  output  $clog2(BLOCK_WORDS)  word position of current beat in line
ic_done_o  output  1  one-cycle pulse on last icache beat
dc_done_o  output  1  one-cycle pulse on last dcache beat
mem_req_o  output  1  burst request to memory
mem_addr_o  output  ADDR_W  line-aligned burst base address
mem_ack_i  input  1  memory accepts burst (sampled while mem_req_o=1)
mem_rvalid_i  input  1  memory beat valid
mem_rdata_i  input  DATA_W  memory beat data

Behaviour:
- Reset (async assert, sync release): state=IDLE, owner=DC, last_grant=DC, beat counter=0. All outputs 0: mem_req_o, mem_addr_o, all rvalid, done, word_idx_o, rdata_o.
- FSM states: IDLE, REQ, XFER.
- IDLE, arbitration on registered decision:
  - Only ic_req_i (and not ic_cancel_i): owner=IC.
  - Only dc_req_i: owner=DC.
  - Both: owner = requester other than last_grant.
  - ic_req_i with ic_cancel_i in the same cycle is ignored.
  - Next cycle: state=REQ, mem_req_o=1, mem_addr_o = owner address with low $clog2(BLOCK_WORDS*DATA_W/8) bits cleared, last_grant=owner.
  - Grant latency is 1 cycle from request to mem_req_o.
- REQ:
  - mem_req_o and mem_addr_o held stable until mem_ack_i.
  - mem_ack_i=1: next state=XFER, counter=0, mem_req_o=0 next cycle.
  - owner=IC and ic_cancel_i=1 with mem_ack_i=0: mem_req_o drops next cycle, state returns to IDLE, no done pulse.
  - Cancel and mem_ack_i in the same cycle: ack wins and the burst proceeds.
- XFER:
  - Each cycle with mem_rvalid_i: owner's rvalid_o=1 (combinational from mem_rvalid_i), rdata_o=mem_rdata_i, word_idx_o=counter, counter increments.
  - Non-owner rvalid is always 0. Beats may be non-contiguous.
  - On beat with counter=BLOCK_WORDS-1: owner's done_o pulses the same cycle, counter wraps to 0, next state=IDLE.
  - ic_cancel_i is ignored in XFER. The burst completes and beats are still delivered; the icache discards them.
  - mem_rvalid_i outside XFER is ignored (no rvalid out).
- A requester must deassert req the cycle after its done pulse. A req still high in IDLE is treated as a new request.
- Back-to-back: if both requested, the loser is granted on the first IDLE cycle after the winner's done, giving a 1-cycle IDLE bubble.
- Reset asserted mid-burst: immediate return to IDLE, outputs cleared, partial line never signals done.

Test Plan:
- Single IC refill: ic_addr_i=0x0000_1234, BLOCK_WORDS=16, DATA_W=32 -> mem_addr_o=0x0000_1200 one cycle later; ack; 16 beats -> ic_rvalid_o x16, word_idx_o 0..15, ic_done_o on 16th beat only, dc_rvalid_o never high.
- Simultaneous requests out of reset -> IC granted first (last_grant=DC). After ic_done_o, DC granted with mem_req_o 2 cycles after ic_done_o; a third tie goes to IC again.
- Gapped beats: mem_rvalid_i pattern 1,0,0,1,... -> word_idx_o advances only on valid beats; done on the 16th valid beat.
- Cancel in REQ: IC request, mem_ack_i held 0 three cycles, ic_cancel_i pulsed -> mem_req_o low next cycle, IDLE, no ic_done_o. Pending dc_req_i is then granted.
- Cancel coincident with mem_ack_i, and cancel during XFER -> burst completes, all 16 beats delivered, ic_done_o pulses.
- reset_n_i low asynchronously at beat 7 -> outputs 0 before next clock edge; after release a fresh request restarts at word_idx_o=0.
